dram_dq_responder: RTL and testbench

//  Device-side data-path responder for the DRAM data-transfer link: the far end of the

---
 rtl/dram_pkg.sv | 39 +++
 rtl/dram_beat_counter.sv | 73 +++++++
 rtl/dram_dq_responder.sv | 192 +++++++++++++++++++
 tb/tb_dram_dq_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dram_pkg
// Description : Shared constants, burst type and data-path FSM state encoding
//               for the device-side DQ/DQS/DM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_pkg;

  localparam int DQ_W = 8;   // data pins per beat
  localparam int BL   = 8;   // beats per burst (power of 2)
  localparam int WL   = 4;   // write latency, >= 1
  localparam int RL   = 6;   // read latency, >= 2

  localparam int BEAT_W  = $clog2(BL);
  localparam int MAX_LAT = (WL > RL) ? WL : RL;
  // Sized so a full latency-plus-burst sequence never wraps.
  localparam int CNT_W   = $clog2(MAX_LAT + BL) + 1;

  typedef logic [BL*DQ_W-1:0] burst_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_WAIT  = 3'd1,
    ST_WR_BURST = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_PRE   = 3'd4,
    ST_RD_BURST = 3'd5,
    ST_RD_POST  = 3'd6
  } dq_state_t;

  // Sequential wrap ordering: beat k lands on array index (col + k) mod BL.
  function automatic logic [BEAT_W-1:0] beat_index(input logic [BEAT_W-1:0] col,
                                                   input logic [BEAT_W-1:0] k);
    return col + k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : dram_beat_counter
// Description : Latency/beat sequencer. load_i starts a wait phase of lat_i
//               cycles (lat_i >= 1); wait_last_o flags its final cycle.
//               start_i begins a burst phase counting beats 0..BL-1;
//               beat_last_o flags beat BL-1, after which the counter idles.
// Revision    : 1.0 - initial release
// Ports       : clk_i, nrst_i   clock, synchronous active-low reset
//               load_i, lat_i   begin wait phase of lat_i cycles
//               start_i         begin burst phase at beat 0
//               wait_last_o     last cycle of wait phase
//               beat_o          current beat index k
//               beat_last_o     current beat is BL-1
// ============================================================================
module dram_beat_counter
  import dram_pkg::*;
(
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              load_i,
  input  logic [CNT_W-1:0]  lat_i,
  input  logic              start_i,
  output logic              wait_last_o,
  output logic [BEAT_W-1:0] beat_o,
  output logic              beat_last_o
);

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_WAIT  = 2'd1,
    PH_BURST = 2'd2
  } phase_t;

  phase_t           phase_q;
  logic [CNT_W-1:0] cnt_q;

  assign wait_last_o = (phase_q == PH_WAIT)  && (cnt_q == '0);
  assign beat_last_o = (phase_q == PH_BURST) && (cnt_q == CNT_W'(BL-1));
  assign beat_o      = cnt_q[BEAT_W-1:0];

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
    end else if (load_i) begin
      // Counts remaining wait cycles down to zero.
      phase_q <= PH_WAIT;
      cnt_q   <= lat_i - CNT_W'(1);
    end else if (start_i) begin
      phase_q <= PH_BURST;
      cnt_q   <= '0;
    end else begin
      case (phase_q)
        PH_WAIT: begin
          if (cnt_q == '0) phase_q <= PH_IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        PH_BURST: begin
          if (beat_last_o) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_dq_responder.sv
`default_nettype none
// ============================================================================
// Module      : dram_dq_responder
// Description : Device-side DQ/DQS/DM data-path responder. Captures write
//               bursts WL cycles after wr_cmd and drives read bursts RL cycles
//               after rd_cmd with a one-cycle DQS preamble and postamble.
// Revision    : 1.0 - initial release
// Ports       : clk_i, nrst_i        clock, synchronous active-low reset
//               wr_cmd_i, rd_cmd_i   one-cycle command strobes
//               col_choice_i         starting beat (sequential wrap)
//               rd_data_i            read burst from array, latched on accept
//               dq_in_i, dqs_t_in_i, dm_n_in_i   controller write pins
//               dq_out_o, dq_oe_o    read beat and DQ enable
//               dqs_t_out_o, dqs_c_out_o, dqs_oe_o   read strobe pair/enable
//               wr_data_o, wr_mask_o, wr_valid_o     assembled write burst
//               busy_o               state != IDLE
//               cmd_err_o            pulse: command dropped
//               strobe_err_o         sticky: write strobe phase wrong
// ============================================================================
module dram_dq_responder
  import dram_pkg::*;
(
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              wr_cmd_i,
  input  logic              rd_cmd_i,
  input  logic [BEAT_W-1:0] col_choice_i,
  input  logic [BL*DQ_W-1:0] rd_data_i,
  input  logic [DQ_W-1:0]   dq_in_i,
  input  logic              dqs_t_in_i,
  input  logic              dm_n_in_i,
  output logic [DQ_W-1:0]   dq_out_o,
  output logic              dq_oe_o,
  output logic              dqs_t_out_o,
  output logic              dqs_c_out_o,
  output logic              dqs_oe_o,
  output logic [BL*DQ_W-1:0] wr_data_o,
  output logic [BL-1:0]     wr_mask_o,
  output logic              wr_valid_o,
  output logic              busy_o,
  output logic              cmd_err_o,
  output logic              strobe_err_o
);

  dq_state_t         state_q, state_d;
  logic [BEAT_W-1:0] col_q;
  burst_t            rd_buf_q;
  burst_t            wr_data_q;
  logic [BL-1:0]     wr_mask_q;
  logic              wr_valid_q;
  logic              strobe_err_q;
  logic              cmd_err_q, cmd_err_d;
  logic [DQ_W-1:0]   dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              dqs_oe_q, dqs_oe_d;
  logic              dqs_t_q, dqs_t_d;
  logic              dqs_c_q, dqs_c_d;

  logic              cnt_load, cnt_start, accept_rd;
  logic [CNT_W-1:0]  cnt_lat;
  logic              wait_last, beat_last;
  logic [BEAT_W-1:0] beat, beat_d;
  logic [BEAT_W-1:0] wr_idx, rd_idx;

  dram_beat_counter u_beat_counter (
    .clk_i       (clk_i),
    .nrst_i      (nrst_i),
    .load_i      (cnt_load),
    .lat_i       (cnt_lat),
    .start_i     (cnt_start),
    .wait_last_o (wait_last),
    .beat_o      (beat),
    .beat_last_o (beat_last)
  );

  assign wr_idx = beat_index(col_q, beat);
  assign rd_idx = beat_index(col_q, beat_d);

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_lat   = '0;
    cnt_start = 1'b0;
    accept_rd = 1'b0;
    cmd_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_cmd_i && rd_cmd_i) begin
          cmd_err_d = 1'b1;
        end else if (wr_cmd_i) begin
          if (WL > 1) begin
            state_d  = ST_WR_WAIT;
            cnt_load = 1'b1;
            cnt_lat  = CNT_W'(WL-1);
          end else begin
            state_d   = ST_WR_BURST;
            cnt_start = 1'b1;
          end
        end else if (rd_cmd_i) begin
          accept_rd = 1'b1;
          // RL-2 wait cycles, then the single preamble cycle.
          if (RL > 2) begin
            state_d  = ST_RD_WAIT;
            cnt_load = 1'b1;
            cnt_lat  = CNT_W'(RL-2);
          end else begin
            state_d = ST_RD_PRE;
          end
        end
      end
      ST_WR_WAIT: begin
        if (wait_last) begin
          state_d   = ST_WR_BURST;
          cnt_start = 1'b1;
        end
      end
      ST_WR_BURST: if (beat_last) state_d = ST_IDLE;
      ST_RD_WAIT:  if (wait_last) state_d = ST_RD_PRE;
      ST_RD_PRE: begin
        state_d   = ST_RD_BURST;
        cnt_start = 1'b1;
      end
      ST_RD_BURST: if (beat_last) state_d = ST_RD_POST;
      ST_RD_POST:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && (wr_cmd_i || rd_cmd_i)) cmd_err_d = 1'b1;

    // Pad outputs are registered, so they are computed for the next state
    // and the beat the counter will hold in it.
    beat_d   = cnt_start ? '0 : beat + BEAT_W'(1);
    dq_oe_d  = (state_d == ST_RD_BURST);
    dqs_oe_d = (state_d == ST_RD_PRE) || (state_d == ST_RD_BURST) ||
               (state_d == ST_RD_POST);
    dqs_t_d  = dq_oe_d && !beat_d[0];
    dqs_c_d  = dqs_oe_d && !dqs_t_d;
    dq_out_d = dq_oe_d ? rd_buf_q[rd_idx*DQ_W +: DQ_W] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      rd_buf_q     <= '0;
      wr_data_q    <= '0;
      wr_mask_q    <= '0;
      wr_valid_q   <= 1'b0;
      strobe_err_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      dqs_oe_q     <= 1'b0;
      dqs_t_q      <= 1'b0;
      dqs_c_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_err_q  <= cmd_err_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      dqs_oe_q   <= dqs_oe_d;
      dqs_t_q    <= dqs_t_d;
      dqs_c_q    <= dqs_c_d;
      wr_valid_q <= (state_q == ST_WR_BURST) && beat_last;

      if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) col_q <= col_choice_i;
      if (accept_rd) rd_buf_q <= rd_data_i;

      if (state_q == ST_WR_BURST) begin
        wr_data_q[wr_idx*DQ_W +: DQ_W] <= dq_in_i;
        wr_mask_q[wr_idx]              <= ~dm_n_in_i;
        // Strobe is high on even beats, low on odd beats.
        if (dqs_t_in_i != ~beat[0]) strobe_err_q <= 1'b1;
      end
    end
  end

  assign dq_out_o     = dq_out_q;
  assign dq_oe_o      = dq_oe_q;
  assign dqs_t_out_o  = dqs_t_q;
  assign dqs_c_out_o  = dqs_c_q;
  assign dqs_oe_o     = dqs_oe_q;
  assign wr_data_o    = wr_data_q;
  assign wr_mask_o    = wr_mask_q;
  assign wr_valid_o   = wr_valid_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign cmd_err_o    = cmd_err_q;
  assign strobe_err_o = strobe_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_dq_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_dq_responder
// Description : Directed self-checking bench for dram_dq_responder. Expected
//               write bursts and read beats are queued when commands are
//               issued and compared when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_dq_responder;

  localparam int DQ_W = 8;
  localparam int BL   = 8;
  localparam int WL   = 4;
  localparam int RL   = 6;

  logic              clk = 1'b0;
  logic              nrst;
  logic              wr_cmd, rd_cmd;
  logic [2:0]        col_choice;
  logic [BL*DQ_W-1:0] rd_data;
  logic [DQ_W-1:0]   dq_in;
  logic              dqs_t_in, dm_n_in;
  logic [DQ_W-1:0]   dq_out;
  logic              dq_oe, dqs_t_out, dqs_c_out, dqs_oe;
  logic [BL*DQ_W-1:0] wr_data;
  logic [BL-1:0]     wr_mask;
  logic              wr_valid, busy, cmd_err, strobe_err;

  int errors = 0;
  int checks = 0;
  bit exp_serr = 1'b0;

  logic [63:0] wq[$];
  logic [7:0]  mq[$];
  logic [7:0]  rq[$];

  always #5 clk = ~clk;

  dram_dq_responder dut (
    .clk_i        (clk),
    .nrst_i       (nrst),
    .wr_cmd_i     (wr_cmd),
    .rd_cmd_i     (rd_cmd),
    .col_choice_i (col_choice),
    .rd_data_i    (rd_data),
    .dq_in_i      (dq_in),
    .dqs_t_in_i   (dqs_t_in),
    .dm_n_in_i    (dm_n_in),
    .dq_out_o     (dq_out),
    .dq_oe_o      (dq_oe),
    .dqs_t_out_o  (dqs_t_out),
    .dqs_c_out_o  (dqs_c_out),
    .dqs_oe_o     (dqs_oe),
    .wr_data_o    (wr_data),
    .wr_mask_o    (wr_mask),
    .wr_valid_o   (wr_valid),
    .busy_o       (busy),
    .cmd_err_o    (cmd_err),
    .strobe_err_o (strobe_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] col, input logic [7:0] base,
                          input logic [7:0] dmn, input bit stuck, input bit rd_hit);
    logic [63:0] ed;
    logic [7:0]  em;
    logic [7:0]  bv;
    int          idx;
    int          k;
    bit          seen;
    ed = '0;
    em = '0;
    for (int b = 0; b < BL; b++) begin
      idx = (col + b) % BL;
      bv  = base + 8'(b);
      ed[idx*8 +: 8] = bv;
      em[idx] = ~dmn[b];
    end
    wq.push_back(ed);
    mq.push_back(em);

    wr_cmd = 1'b1;
    col_choice = col;
    tick();                              // accept edge 0
    wr_cmd = 1'b0;
    col_choice = 3'd0;
    chk("wr_busy", busy, 1);
    seen = 1'b0;
    for (int e = 1; e <= WL + BL; e++) begin
      if (e >= WL && e < WL + BL) begin
        k = e - WL;
        dq_in    = base + 8'(k);
        dm_n_in  = dmn[k];
        dqs_t_in = stuck ? 1'b1 : ((k % 2) == 0);
      end else begin
        dq_in    = '0;
        dm_n_in  = 1'b1;
        dqs_t_in = 1'b0;
      end
      rd_cmd = rd_hit && (e == 6);
      tick();                            // now past edge e
      rd_cmd = 1'b0;
      if (stuck && e == WL + 1) exp_serr = 1'b1;
      chk("strobe_err", strobe_err, exp_serr);
      chk("cmd_err_wr", cmd_err, rd_hit && (e == 6));
      chk("wr_no_drive", {dq_oe, dqs_oe}, 2'b00);
      if (wr_valid) begin
        seen = 1'b1;
        chk("wr_valid_edge", e, WL + BL - 1);
        chk("wr_idle_at_valid", busy, 0);
        if (wq.size() == 0) chk("wr_queue_empty", 1, 0);
        else begin
          chk("wr_data", wr_data, wq.pop_front());
          chk("wr_mask", wr_mask, mq.pop_front());
        end
      end
    end
    dq_in = '0;
    dm_n_in = 1'b1;
    dqs_t_in = 1'b0;
    chk("wr_valid_seen", seen, 1);
  endtask

  task automatic do_read(input logic [2:0] col, input logic [63:0] data, input int rst_at);
    logic [63:0] tmp;
    bit exp_oe, exp_soe, exp_t;
    for (int b = 0; b < BL; b++) begin
      tmp = data >> (((col + b) % BL) * 8);
      rq.push_back(tmp[7:0]);
    end
    rd_cmd = 1'b1;
    col_choice = col;
    rd_data = data;
    tick();                              // accept edge 0
    rd_cmd = 1'b0;
    col_choice = 3'd0;
    rd_data = ~data;                     // burst must come from the latched copy
    chk("rd_busy", busy, 1);
    for (int e = 1; e <= RL + BL; e++) begin
      if (e == rst_at) nrst = 1'b0;
      tick();
      if (e == rst_at) begin
        exp_serr = 1'b0;
        chk("rst_dq_oe", dq_oe, 0);
        chk("rst_dqs_oe", dqs_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dq_out", dq_out, 0);
        chk("rst_strobe_err", strobe_err, 0);
        rq.delete();
        nrst = 1'b1;
        tick();
        return;
      end
      exp_oe  = (e >= RL - 1) && (e <= RL + BL - 2);
      exp_soe = (e >= RL - 2) && (e <= RL + BL - 1);
      exp_t   = exp_oe && (((e - (RL - 1)) % 2) == 0);
      chk("rd_dq_oe", dq_oe, exp_oe);
      chk("rd_dqs_oe", dqs_oe, exp_soe);
      chk("rd_dqs_t", dqs_t_out, exp_t);
      chk("rd_dqs_c", dqs_c_out, exp_soe && !exp_t);
      chk("rd_busy_seq", busy, e <= RL + BL - 1);
      chk("rd_strobe_err", strobe_err, exp_serr);
      if (dq_oe) begin
        if (rq.size() == 0) chk("rd_queue_empty", 1, 0);
        else chk("rd_beat", dq_out, rq.pop_front());
      end else begin
        chk("rd_dq_out_idle", dq_out, 0);
      end
    end
    chk("rd_beats_left", rq.size(), 0);
    rd_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = 1'b0;
    wr_cmd = 1'b0;
    rd_cmd = 1'b0;
    col_choice = 3'd0;
    rd_data = '0;
    dq_in = '0;
    dqs_t_in = 1'b0;
    dm_n_in = 1'b1;
    tick();
    tick();
    chk("rst_state", {dq_oe, dqs_oe, dqs_t_out, dqs_c_out, wr_valid, busy, cmd_err, strobe_err}, 8'h00);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_mask", wr_mask, 0);
    chk("rst_dq_out", dq_out, 0);
    nrst = 1'b1;
    tick();

    // Plain write, column 0, no mask.
    do_write(3'd0, 8'h01, 8'hFF, 1'b0, 1'b0);
    // Wrapped write with beat 2 masked.
    do_write(3'd5, 8'hA0, 8'b1111_1011, 1'b0, 1'b0);
    // Read issued mid-write is dropped; write completes intact.
    do_write(3'd2, 8'h10, 8'hFF, 1'b0, 1'b1);

    // Both commands together in IDLE: dropped, no state change.
    wr_cmd = 1'b1;
    rd_cmd = 1'b1;
    tick();
    wr_cmd = 1'b0;
    rd_cmd = 1'b0;
    chk("collide_err", cmd_err, 1);
    chk("collide_busy", busy, 0);
    tick();
    chk("collide_err_pulse", cmd_err, 0);

    // Strobe stuck high: error at beat 1, data still captured, sticky.
    do_write(3'd1, 8'h40, 8'hFF, 1'b1, 1'b0);

    // Read, column 3.
    do_read(3'd3, 64'h7766_5544_3322_1100, -1);
    // Read aborted by reset at cycle 8, then a write is accepted.
    do_read(3'd0, 64'hF0E1_D2C3_B4A5_9687, 8);
    do_write(3'd7, 8'hC8, 8'b0111_1111, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
